// File: rtl/universal_shift_reg.sv
// Universal shift register: manual hold/shift/load plus counted burst shifts, all on the falling clock edge.
// Optional feature macro USR_ROTATE_EN: with rot=1, shifts recirculate the outgoing bit instead of sr_in/sl_in.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] d,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] cnt,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rem;
  logic             dir_l;
  logic             ins_r;
  logic             ins_l;

  function automatic logic [WIDTH-1:0] shift_r(input logic [WIDTH-1:0] v, input logic b);
    return {b, v[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_l(input logic [WIDTH-1:0] v, input logic b);
    return {v[WIDTH-2:0], b};
  endfunction

`ifdef USR_ROTATE_EN
  assign ins_r = rot ? q[0]       : sr_in;
  assign ins_l = rot ? q[WIDTH-1] : sl_in;
`else
  logic rot_unused;
  assign rot_unused = rot;
  assign ins_r      = sr_in;
  assign ins_l      = sl_in;
`endif

  assign so_r = q[0];
  assign so_l = q[WIDTH-1];

  always_ff @(negedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cnt != '0) ? SHIFT : DONE;
      SHIFT:   if (rem == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // A start request in IDLE takes priority over the manual mode on that edge.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      rem   <= '0;
      dir_l <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (cnt != '0) begin
              dir_l <= dir;
              rem   <= cnt;
            end
          end else begin
            case (s)
              2'b01:   q <= shift_r(q, ins_r);
              2'b10:   q <= shift_l(q, ins_l);
              2'b11:   q <= d;
              default: q <= q;
            endcase
          end
        end
        SHIFT: begin
          q   <= dir_l ? shift_l(q, ins_l) : shift_r(q, ins_r);
          rem <= rem - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed-vector bench for universal_shift_reg (default WIDTH=8, CNT_W=4); follows USR_ROTATE_EN if defined.
module tb_universal_shift_reg;

  logic       clk;
  logic       reset;
  logic [1:0] s;
  logic [7:0] d;
  logic       sr_in;
  logic       sl_in;
  logic       start;
  logic       dir;
  logic [3:0] cnt;
  logic       rot;
  logic [7:0] q;
  logic       so_r;
  logic       so_l;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  universal_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .s(s), .d(d), .sr_in(sr_in), .sl_in(sl_in),
    .start(start), .dir(dir), .cnt(cnt), .rot(rot),
    .q(q), .so_r(so_r), .so_l(so_l), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change right after a rising edge; the falling edge in between commits them.
  task automatic cycle();
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL reset_q: got %h want 00", q); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_manual();
    s = 2'b11; d = 8'hA5;
    cycle();
    n_cmp++; if (q !== 8'hA5) begin n_err++; $display("FAIL load_q: got %h want a5", q); end
    s = 2'b01; sr_in = 1'b1;
    cycle();
    n_cmp++; if (q !== 8'hD2) begin n_err++; $display("FAIL shr_q: got %h want d2", q); end
    n_cmp++; if (so_r !== 1'b0) begin n_err++; $display("FAIL shr_so_r: got %b want 0", so_r); end
    n_cmp++; if (so_l !== 1'b1) begin n_err++; $display("FAIL shr_so_l: got %b want 1", so_l); end
    s = 2'b10; sl_in = 1'b1; sr_in = 1'b0;
    cycle();
    n_cmp++; if (q !== 8'hA5) begin n_err++; $display("FAIL shl_q: got %h want a5", q); end
    s = 2'b00; d = 8'h00;
    cycle();
    n_cmp++; if (q !== 8'hA5) begin n_err++; $display("FAIL hold_q: got %h want a5", q); end
  endtask

  task automatic test_burst_left();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h81; exp_q[1] = 8'h02; exp_q[2] = 8'h04;
    s = 2'b11; d = 8'h81;
    cycle();
    s = 2'b00; sl_in = 1'b0; start = 1'b1; dir = 1'b1; cnt = 4'd3;
    cycle();
    start = 1'b0; dir = 1'b0; cnt = 4'd0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL burst_busy[%0d]: got %b want 1", i, busy); end
      n_cmp++; if (q !== exp_q[i]) begin n_err++; $display("FAIL burst_q[%0d]: got %h want %h", i, q, exp_q[i]); end
      cycle();
    end
    n_cmp++; if (q !== 8'h08) begin n_err++; $display("FAIL burst_end_q: got %h want 08", q); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL burst_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_done_busy: got %b want 0", busy); end
    cycle();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL burst_idle_done: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_idle_busy: got %b want 0", busy); end
    n_cmp++; if (q !== 8'h08) begin n_err++; $display("FAIL burst_idle_q: got %h want 08", q); end
  endtask

  task automatic test_cnt_zero();
    start = 1'b1; cnt = 4'd0; dir = 1'b0; sr_in = 1'b1;
    cycle();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cnt0_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL cnt0_done: got %b want 1", done); end
    n_cmp++; if (q !== 8'h08) begin n_err++; $display("FAIL cnt0_q: got %h want 08", q); end
    cycle();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL cnt0_after_done: got %b want 0", done); end
    n_cmp++; if (q !== 8'h08) begin n_err++; $display("FAIL cnt0_after_q: got %h want 08", q); end
    sr_in = 1'b0;
  endtask

  task automatic test_start_during_busy();
    start = 1'b1; dir = 1'b0; cnt = 4'd2; sr_in = 1'b0;
    cycle();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rb_busy0: got %b want 1", busy); end
    s = 2'b11; d = 8'hFF; dir = 1'b1; cnt = 4'd7;
    cycle();
    n_cmp++; if (q !== 8'h04) begin n_err++; $display("FAIL rb_q1: got %h want 04", q); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rb_busy1: got %b want 1", busy); end
    cycle();
    n_cmp++; if (q !== 8'h02) begin n_err++; $display("FAIL rb_q2: got %h want 02", q); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rb_done: got %b want 1", done); end
    cycle();
    s = 2'b00; start = 1'b0; dir = 1'b0; cnt = 4'd0; d = 8'h00;
    n_cmp++; if (q !== 8'h02) begin n_err++; $display("FAIL rb_final_q: got %h want 02", q); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rb_final_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rb_final_done: got %b want 0", done); end
  endtask

  task automatic test_rotate();
    logic [7:0] exp_burst;
    logic [7:0] exp_manual;
`ifdef USR_ROTATE_EN
    exp_burst = 8'hC0; exp_manual = 8'h81;
`else
    exp_burst = 8'h40; exp_manual = 8'h80;
`endif
    s = 2'b11; d = 8'h81;
    cycle();
    s = 2'b00; rot = 1'b1; sr_in = 1'b0; sl_in = 1'b0; start = 1'b1; dir = 1'b0; cnt = 4'd1;
    cycle();
    start = 1'b0; cnt = 4'd0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rot_busy: got %b want 1", busy); end
    cycle();
    n_cmp++; if (q !== exp_burst) begin n_err++; $display("FAIL rot_burst_q: got %h want %h", q, exp_burst); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rot_done: got %b want 1", done); end
    cycle();
    s = 2'b10;
    cycle();
    s = 2'b00; rot = 1'b0;
    n_cmp++; if (q !== exp_manual) begin n_err++; $display("FAIL rot_manual_q: got %h want %h", q, exp_manual); end
  endtask

  task automatic test_reset_mid_burst();
    s = 2'b11; d = 8'h5A;
    cycle();
    s = 2'b00; start = 1'b1; dir = 1'b0; cnt = 4'd5; sr_in = 1'b1;
    cycle();
    start = 1'b0; cnt = 4'd0;
    cycle();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL mid_reset_q: got %h want 00", q); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_reset_done: got %b want 0", done); end
    cycle();
    reset = 1'b0;
    cycle();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL post_reset_done: got %b want 0", done); end
    n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL post_reset_q: got %h want 00", q); end
    sr_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; s = 2'b00; d = 8'h00; sr_in = 1'b0; sl_in = 1'b0;
    start = 1'b0; dir = 1'b0; cnt = 4'd0; rot = 1'b0;
    test_reset();
    test_manual();
    test_burst_left();
    test_cnt_zero();
    test_start_during_busy();
    test_rotate();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the burst count width, so a burst is at most 2^CNT_W-1 shifts.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on the falling edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port s, input, 2 bits: manual mode; 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 The block SHALL have port d, input, WIDTH bits: parallel load data.
REQ-007 The block SHALL have port sr_in, input, 1 bit: serial input entering q[WIDTH-1] on a right shift.
REQ-008 The block SHALL have port sl_in, input, 1 bit: serial input entering q[0] on a left shift.
REQ-009 The block SHALL have port start, input, 1 bit: burst request.
REQ-010 The block SHALL have port dir, input, 1 bit: burst direction, 0 right and 1 left, sampled with start.
REQ-011 The block SHALL have port cnt, input, CNT_W bits: number of burst shifts, sampled with start.
REQ-012 The block SHALL have port rot, input, 1 bit: rotate select (see Configuration).
REQ-013 The block SHALL have port q, output, WIDTH bits: register contents.
REQ-014 The block SHALL have port so_r, output, 1 bit: equal to q[0], the bit shifted out on a right shift.
REQ-015 The block SHALL have port so_l, output, 1 bit: equal to q[WIDTH-1], the bit shifted out on a left shift.
REQ-016 The block SHALL have port busy, output, 1 bit: high while a burst is in progress.
REQ-017 The block SHALL have port done, output, 1 bit: single-cycle pulse marking burst completion.

Function
REQ-018 In state IDLE, each falling edge SHALL apply s: 00 holds q; 01 sets q to {sr_in, q[WIDTH-1:1]}; 10 sets q to {q[WIDTH-2:0], sl_in}; 11 sets q to d.
REQ-019 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-020 From IDLE, start=1 with cnt>0 SHALL latch dir, load a remaining counter with cnt, go to SHIFT and suppress the manual operation on that edge.
REQ-021 From IDLE, start=1 with cnt=0 SHALL go directly to DONE without changing q.
REQ-022 In SHIFT, each edge SHALL shift q once in the latched direction using sr_in/sl_in and decrement the counter; when the counter reaches 0 the FSM SHALL go to DONE.
REQ-023 A burst of N SHALL produce exactly N shifts in N consecutive cycles.
REQ-024 DONE SHALL last one cycle with done=1, hold q, and then return to IDLE.
REQ-025 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE.
REQ-026 In SHIFT and DONE, s, start, dir and cnt SHALL be ignored; start during busy or done SHALL be dropped, not queued.
REQ-027 so_r and so_l SHALL be combinational from q.

Reset
REQ-028 reset=1 SHALL immediately, independent of clk, force q=0, state=IDLE, counter=0, busy=0 and done=0.
REQ-029 Reset asserted mid-burst SHALL abort the burst with no done pulse; after release the block SHALL be in IDLE.

Configuration
REQ-030 With macro USR_ROTATE_EN defined and rot=1, right shifts SHALL insert q[0] and left shifts SHALL insert q[WIDTH-1] in both manual and burst operation, ignoring sr_in/sl_in.
REQ-031 Without USR_ROTATE_EN, rot SHALL be ignored and shifts SHALL always use sr_in/sl_in.

Verification
REQ-032 The bench SHALL cover this scenario: reset pulse mid-operation -> q=0x00, busy=0 and done=0 immediately, without a clock edge.
REQ-033 The bench SHALL cover this scenario: s=11 with d=0xA5, then s=01 with sr_in=1 -> q=0xA5, then q=0xD2, with so_r=0.
REQ-034 The bench SHALL cover this scenario: q=0x81, start with dir=1, cnt=3 and sl_in=0 -> busy high for 3 cycles, q=0x08, then done for 1 cycle, then IDLE.
REQ-035 The bench SHALL cover this scenario: start with cnt=0 -> no busy, done pulses on the next edge, q unchanged.
REQ-036 The bench SHALL cover this scenario: start pulsed again during busy, with s=11 -> ignored; burst count and q are unaffected.
REQ-037 The bench SHALL cover this scenario: with USR_ROTATE_EN defined, q=0x81, rot=1, burst right with cnt=1 -> q=0xC0; without the macro and sr_in=0 -> q=0x40.
